// File: rtl/conv_pkg.sv
// ============================================================================
//  Module   : conv_pkg
//  Purpose  : Shared widths, default Gaussian kernel and control-word layout
//             for the 3x3 streaming convolution.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

package conv_pkg;

   localparam int DATA_W_DEF = 10;
   localparam int COEF_W_DEF = 8;
   localparam int N_TAPS     = 9;

   localparam int DEF_KERNEL [N_TAPS] = '{1, 2, 1, 2, 4, 2, 1, 2, 1};
   localparam int DEF_SHIFT  = 4;

   localparam int CTRL_ADDR       = 9;
   localparam int CTRL_SHIFT_LSB  = 0;
   localparam int CTRL_SHIFT_MSB  = 3;
   localparam int CTRL_ABS_BIT    = 4;
   localparam int CTRL_BYPASS_BIT = 5;

   typedef struct packed {
      logic       bypass;
      logic       abs_en;
      logic [3:0] shift;
   } ctrl_t;

   localparam ctrl_t DEF_CTRL = '{bypass: 1'b0, abs_en: 1'b0, shift: 4'(DEF_SHIFT)};

   // Nine products of (DATA_W+1)x COEF_W signed operands need 4 guard bits.
   function automatic int acc_width(input int dw, input int cw);
      return dw + cw + 4;
   endfunction

endpackage

`default_nettype wire

// File: rtl/conv3x3_stream_if.sv
// ============================================================================
//  Module   : conv3x3_stream_if
//  Purpose  : Pixel stream, kernel-write port and filtered output bundle.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

interface conv3x3_stream_if #(
   parameter int DATA_W = conv_pkg::DATA_W_DEF,
   parameter int COEF_W = conv_pkg::COEF_W_DEF
);
   logic              idata_valid;
   logic [DATA_W-1:0] data_in;
   logic              sof;
   logic              coef_we;
   logic [3:0]        coef_addr;
   logic [COEF_W-1:0] coef_data;
   logic [DATA_W-1:0] data_o;
   logic              odata_valid;

   modport master (
      output idata_valid, data_in, sof, coef_we, coef_addr, coef_data,
      input  data_o, odata_valid
   );

   modport slave (
      input  idata_valid, data_in, sof, coef_we, coef_addr, coef_data,
      output data_o, odata_valid
   );
endinterface

`default_nettype wire

// File: rtl/line_buffer_2tap.sv
// ============================================================================
//  Module   : line_buffer_2tap
//  Purpose  : Column-addressed two-line delay; returns the pixels one and two
//             lines above the current column.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module line_buffer_2tap #(
   parameter int DATA_W = 10,
   parameter int IMG_W  = 640,
   parameter int COL_W  = 10
) (
   input  wire logic              clk_in,
   input  wire logic              en,
   input  wire logic [COL_W-1:0]  addr,
   input  wire logic [DATA_W-1:0] din,
   output logic      [DATA_W-1:0] tap1,
   output logic      [DATA_W-1:0] tap2
);
   logic [DATA_W-1:0] line1_q [IMG_W];
   logic [DATA_W-1:0] line2_q [IMG_W];

   assign tap1 = line1_q[addr];
   assign tap2 = line2_q[addr];

   // Contents are never cleared; only fully primed windows are ever emitted.
   always_ff @(posedge clk_in) begin
      if (en) begin
         line1_q[addr] <= din;
         line2_q[addr] <= line1_q[addr];
      end
   end
endmodule

`default_nettype wire

// File: rtl/conv3x3_stream.sv
// ============================================================================
//  Module   : conv3x3_stream
//  Purpose  : 3x3 streaming convolution with shadow kernel, round/shift,
//             optional |x| and clamp; emits interior pixels only.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module conv3x3_stream
   import conv_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int COEF_W = COEF_W_DEF,
   parameter int IMG_W  = 640,
   parameter int COL_W  = 10,
   parameter int ACC_W  = acc_width(DATA_W, COEF_W)
) (
   input wire logic        clk_in,
   input wire logic        rst,
   conv3x3_stream_if.slave bus
);
   localparam int                       PROD_W   = DATA_W + COEF_W + 1;
   localparam logic [COL_W-1:0]         COL_LAST = COL_W'(IMG_W - 1);
   localparam logic signed [ACC_W:0]    PIX_MAX  = (ACC_W+1)'((1 << DATA_W) - 1);

   logic        [COL_W-1:0]  col_q, col_d, cur_col;
   logic        [1:0]        row_q, row_d, cur_row;
   logic signed [COEF_W-1:0] shadow_k_q [N_TAPS], shadow_k_d [N_TAPS];
   logic signed [COEF_W-1:0] active_k_q [N_TAPS], active_k_d [N_TAPS];
   ctrl_t                    shadow_c_q, shadow_c_d, active_c_q, active_c_d;
   logic        [DATA_W-1:0] win_q [N_TAPS], win_d [N_TAPS];
   logic        [DATA_W-1:0] tap1, tap2;

   logic signed [PROD_W-1:0] prod_q [N_TAPS], prod_d [N_TAPS];
   logic signed [ACC_W-1:0]  sum_q, sum_d;
   ctrl_t                    c1_q, c1_d, c2_q, c2_d;
   logic        [DATA_W-1:0] ctr1_q, ctr1_d, ctr2_q, ctr2_d;
   logic                     v0_q, v0_d, v1_q, v1_d, v2_q, v2_d;
   logic        [DATA_W-1:0] data_q, data_d, y;
   logic                     valid_q, valid_d;
   logic signed [ACC_W:0]    bias, rnd, shifted;

   line_buffer_2tap #(.DATA_W(DATA_W), .IMG_W(IMG_W), .COL_W(COL_W)) u_lines (
      .clk_in (clk_in),
      .en     (bus.idata_valid),
      .addr   (cur_col),
      .din    (bus.data_in),
      .tap1   (tap1),
      .tap2   (tap2)
   );

   always_comb begin
      // sof forces the accepted pixel itself to (0,0)
      cur_col    = bus.sof ? '0 : col_q;
      cur_row    = bus.sof ? '0 : row_q;
      col_d      = col_q;
      row_d      = row_q;
      win_d      = win_q;
      v0_d       = 1'b0;
      shadow_k_d = shadow_k_q;
      shadow_c_d = shadow_c_q;
      active_k_d = active_k_q;
      active_c_d = active_c_q;

      if (bus.idata_valid) begin
         if (cur_col == COL_LAST) begin
            col_d = '0;
            row_d = (cur_row == 2'd2) ? cur_row : cur_row + 2'd1;
         end else begin
            col_d = cur_col + COL_W'(1);
            row_d = cur_row;
         end
         for (int r = 0; r < 3; r++) begin
            win_d[3*r]   = win_q[3*r+1];
            win_d[3*r+1] = win_q[3*r+2];
         end
         win_d[2] = tap2;
         win_d[5] = tap1;
         win_d[8] = bus.data_in;
         v0_d     = (cur_row == 2'd2) && (cur_col >= COL_W'(2));
         if (bus.sof) begin
            active_k_d = shadow_k_q;
            active_c_d = shadow_c_q;
         end
      end

      if (bus.coef_we) begin
         if (bus.coef_addr < 4'(CTRL_ADDR)) begin
            shadow_k_d[bus.coef_addr] = bus.coef_data;
         end else if (bus.coef_addr == 4'(CTRL_ADDR)) begin
            shadow_c_d.shift  = bus.coef_data[CTRL_SHIFT_MSB:CTRL_SHIFT_LSB];
            shadow_c_d.abs_en = bus.coef_data[CTRL_ABS_BIT];
            shadow_c_d.bypass = bus.coef_data[CTRL_BYPASS_BIT];
         end
      end

      // Control and centre pixel travel with the data so a new frame's
      // kernel swap cannot disturb results still draining.
      for (int i = 0; i < N_TAPS; i++) begin
         prod_d[i] = PROD_W'($signed({1'b0, win_q[i]}) * active_k_q[i]);
      end
      c1_d   = active_c_q;
      ctr1_d = win_q[4];
      v1_d   = v0_q;

      sum_d = '0;
      for (int i = 0; i < N_TAPS; i++) begin
         sum_d = sum_d + ACC_W'(prod_q[i]);
      end
      c2_d   = c1_q;
      ctr2_d = ctr1_q;
      v2_d   = v1_q;

      bias    = (c2_q.shift == 4'd0) ? '0 : ((ACC_W+1)'(1) << (c2_q.shift - 4'd1));
      rnd     = (ACC_W+1)'(sum_q) + bias;
      shifted = rnd >>> c2_q.shift;
      if (c2_q.abs_en && shifted[ACC_W]) begin
         shifted = -shifted;
      end
      if (c2_q.bypass) begin
         y = ctr2_q;
      end else if (shifted[ACC_W]) begin
         y = '0;
      end else if (shifted > PIX_MAX) begin
         y = '1;
      end else begin
         y = shifted[DATA_W-1:0];
      end
      data_d  = v2_q ? y : data_q;
      valid_d = v2_q;
   end

   always_ff @(posedge clk_in or posedge rst) begin
      if (rst) begin
         col_q <= '0;
         row_q <= '0;
         for (int i = 0; i < N_TAPS; i++) begin
            shadow_k_q[i] <= COEF_W'(DEF_KERNEL[i]);
            active_k_q[i] <= COEF_W'(DEF_KERNEL[i]);
            win_q[i]      <= '0;
            prod_q[i]     <= '0;
         end
         shadow_c_q <= DEF_CTRL;
         active_c_q <= DEF_CTRL;
         sum_q      <= '0;
         c1_q       <= DEF_CTRL;
         c2_q       <= DEF_CTRL;
         ctr1_q     <= '0;
         ctr2_q     <= '0;
         v0_q       <= 1'b0;
         v1_q       <= 1'b0;
         v2_q       <= 1'b0;
         data_q     <= '0;
         valid_q    <= 1'b0;
      end else begin
         col_q      <= col_d;
         row_q      <= row_d;
         shadow_k_q <= shadow_k_d;
         active_k_q <= active_k_d;
         win_q      <= win_d;
         prod_q     <= prod_d;
         shadow_c_q <= shadow_c_d;
         active_c_q <= active_c_d;
         sum_q      <= sum_d;
         c1_q       <= c1_d;
         c2_q       <= c2_d;
         ctr1_q     <= ctr1_d;
         ctr2_q     <= ctr2_d;
         v0_q       <= v0_d;
         v1_q       <= v1_d;
         v2_q       <= v2_d;
         data_q     <= data_d;
         valid_q    <= valid_d;
      end
   end

   assign bus.data_o      = data_q;
   assign bus.odata_valid = valid_q;
endmodule

`default_nettype wire

// File: tb/tb_conv3x3_stream.sv
// ============================================================================
//  Module   : tb_conv3x3_stream
//  Purpose  : Directed, table-driven bench for conv3x3_stream on 8x6 frames.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_conv3x3_stream;
   localparam int DW   = 10;
   localparam int CW   = 8;
   localparam int W    = 8;
   localparam int H    = 6;
   localparam int CLW  = 3;
   localparam int NOUT = (W - 2) * (H - 2);

   typedef struct {
      bit load;
      int kmode;
      int shift;
      bit abs_en;
      bit byp;
      int pval;
      int expv;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_total = 0;
   int   n_bad = 0;
   int   acc_cyc = 0;
   int   first_vcyc = -1;
   int   got[$];
   vec_t vecs [12];

   conv3x3_stream_if #(.DATA_W(DW), .COEF_W(CW)) bus ();

   conv3x3_stream #(.DATA_W(DW), .COEF_W(CW), .IMG_W(W), .COL_W(CLW)) dut (
      .clk_in (clk),
      .rst    (rst),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst === 1'b0 && bus.odata_valid === 1'b1) begin
         if (first_vcyc < 0) first_vcyc = cyc;
         got.push_back(int'(bus.data_o));
      end
   end

   function automatic int kval(input int km, input int i);
      case (km)
         0:       return (i == 4) ? 4 : ((i % 2 == 1) ? 2 : 1);
         1:       return (i == 4) ? 4 : ((i % 2 == 1) ? -1 : 0);
         2:       return 8;
         3:       return -1;
         4:       return (i == 4) ? 1 : 0;
         default: return (i == 4) ? -1 : 0;
      endcase
   endfunction

   function automatic int pix(input int pat, input int fval, input int r, input int c);
      case (pat)
         0:       return fval;
         1:       return (r == 3 && c == 3) ? 50 : 0;
         2:       return ((r + c) % 2 == 1) ? 160 : 0;
         default: return (r * W + c) * 9;
      endcase
   endfunction

   // Hand-derived results at output position (r,c)
   function automatic int expect_at(input int kind, input int fval, input int r, input int c);
      case (kind)
         0: return fval;
         1: begin
            if (r == 3 && c == 3) return 200;
            if ((r == 3 && (c == 2 || c == 4)) || (c == 3 && (r == 2 || r == 4))) return 50;
            return 0;
         end
         2:       return ((r + c) % 2 == 1) ? 160 : 0;
         default: return (r * W + c) * 9;
      endcase
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic wr(input int a, input int d);
      @(negedge clk);
      bus.coef_we   = 1'b1;
      bus.coef_addr = 4'(a);
      bus.coef_data = CW'(d);
      @(negedge clk);
      bus.coef_we   = 1'b0;
   endtask

   task automatic load_kernel(input int km, input int sh, input bit ab, input bit byp);
      for (int i = 0; i < 9; i++) wr(i, kval(km, i));
      wr(9, (int'(byp) << 5) | (int'(ab) << 4) | sh);
      wr(12, 8'h3f);
   endtask

   task automatic send_frame(input int pat, input int fval, input int bub, input int stop_at);
      for (int r = 0; r < H; r++) begin
         for (int c = 0; c < W; c++) begin
            int nb = 0;
            @(negedge clk);
            if (r * W + c == stop_at) begin
               bus.idata_valid = 1'b0;
               bus.sof = 1'b0;
               return;
            end
            while (bub > 0 && nb < 4 && $urandom_range(0, 99) < bub) begin
               bus.idata_valid = 1'b0;
               bus.sof = 1'b0;
               bus.data_in = DW'($urandom);
               nb++;
               @(negedge clk);
            end
            bus.idata_valid = 1'b1;
            bus.sof = (r == 0 && c == 0);
            bus.data_in = DW'(pix(pat, fval, r, c));
            if (r == 2 && c == 2) acc_cyc = cyc + 1;
         end
      end
      @(negedge clk);
      bus.idata_valid = 1'b0;
      bus.sof = 1'b0;
      repeat (6) @(negedge clk);
   endtask

   task automatic check_frame(input string name, input int kind, input int fval);
      chk({name, " count"}, got.size(), NOUT);
      for (int n = 0; n < got.size() && n < NOUT; n++) begin
         int r = n / (W - 2) + 1;
         int c = n % (W - 2) + 1;
         chk($sformatf("%s r%0d c%0d", name, r, c), got[n], expect_at(kind, fval, r, c));
      end
   endtask

   task automatic start_capture();
      got.delete();
      first_vcyc = -1;
   endtask

   initial begin
      vecs[0]  = '{0, 0, 4,  0, 0, 100,  100};
      vecs[1]  = '{1, 1, 0,  1, 0, 77,   0};
      vecs[2]  = '{1, 2, 0,  0, 0, 1023, 1023};
      vecs[3]  = '{1, 3, 0,  0, 0, 1023, 0};
      vecs[4]  = '{1, 3, 0,  1, 0, 5,    45};
      vecs[5]  = '{1, 4, 1,  0, 0, 3,    2};
      vecs[6]  = '{1, 4, 2,  0, 0, 5,    1};
      vecs[7]  = '{1, 5, 1,  1, 0, 3,    1};
      vecs[8]  = '{1, 2, 15, 0, 0, 1023, 2};
      vecs[9]  = '{1, 0, 4,  0, 1, 600,  600};
      vecs[10] = '{1, 0, 0,  0, 0, 60,   960};
      vecs[11] = '{1, 0, 0,  0, 0, 64,   1023};

      bus.idata_valid = 1'b0;
      bus.sof         = 1'b0;
      bus.data_in     = '0;
      bus.coef_we     = 1'b0;
      bus.coef_addr   = '0;
      bus.coef_data   = '0;
      repeat (3) @(negedge clk);
      chk("reset valid", int'(bus.odata_valid), 0);
      chk("reset data", int'(bus.data_o), 0);
      rst = 1'b0;

      for (int v = 0; v < 12; v++) begin
         if (vecs[v].load) load_kernel(vecs[v].kmode, vecs[v].shift, vecs[v].abs_en, vecs[v].byp);
         start_capture();
         send_frame(0, vecs[v].pval, 0, -1);
         check_frame($sformatf("vec%0d", v), 0, vecs[v].expv);
         chk($sformatf("vec%0d latency", v), first_vcyc - acc_cyc, 3);
      end

      load_kernel(1, 0, 1, 0);
      start_capture();
      send_frame(1, 0, 0, -1);
      check_frame("impulse", 1, 0);

      // Kernel rewritten while a frame is streaming only affects the next frame
      load_kernel(0, 4, 0, 0);
      start_capture();
      fork
         send_frame(2, 0, 0, -1);
         begin
            repeat (10) @(negedge clk);
            load_kernel(4, 0, 0, 0);
         end
      join
      check_frame("midframe old", 0, 80);
      start_capture();
      send_frame(2, 0, 0, -1);
      check_frame("midframe new", 2, 0);

      load_kernel(0, 4, 0, 0);
      start_capture();
      send_frame(2, 0, 40, -1);
      check_frame("bubble gauss", 0, 80);
      load_kernel(1, 0, 1, 0);
      start_capture();
      send_frame(1, 0, 40, -1);
      check_frame("bubble impulse", 1, 0);
      load_kernel(0, 4, 0, 1);
      start_capture();
      send_frame(3, 0, 40, -1);
      check_frame("bubble bypass", 3, 0);

      // Abort a frame with reset at pixel (3,4)
      load_kernel(4, 0, 0, 0);
      start_capture();
      send_frame(0, 100, 0, 3 * W + 4);
      rst = 1'b1;
      #1;
      chk("abort valid", int'(bus.odata_valid), 0);
      chk("abort data", int'(bus.data_o), 0);
      chk("abort saw outputs", (got.size() > 0) ? 1 : 0, 1);
      repeat (2) @(negedge clk);
      rst = 1'b0;
      start_capture();
      send_frame(2, 0, 0, -1);
      check_frame("post reset", 0, 80);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end
endmodule

`default_nettype wire
